// File: rtl/program_loader.sv
// Program loader: receives a length-prefixed, XOR-checksummed byte stream and
// writes 15-bit instruction words into the instruction memory while the CPU
// is held. A good load ends with a one-cycle done/pc_clear pulse.
//
// state | meaning
// IDLE  | waiting for start, CPU free to run
// LEN   | waiting for the word-count byte
// HI    | waiting for the high byte of a word (also the write cycle after LO)
// LO    | waiting for the low byte of a word
// CHK   | waiting for the checksum byte (also the write cycle after last LO)
// DONE  | one-cycle completion, done and pc_clear pulse
// ERR   | load failed, CPU held, err sticky until start
module program_loader #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        im_we,
    output logic [7:0]  im_waddr,
    output logic [14:0] im_wdata,
    output logic        cpu_hold,
    output logic        pc_clear,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        HI   = 3'd2,
        LO   = 3'd3,
        CHK  = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } state_t;

    state_t        state;
    logic [7:0]    addr;
    logic [8:0]    cnt;
    logic [7:0]    acc;
    logic [6:0]    hi_bits;
    logic [TW-1:0] tmr;
    logic          xfer;

    assign xfer = rx_valid & rx_ready;

    // Loader FSM with registered outputs; tmr counts down idle cycles and
    // the terminal count at zero trips the timeout on the next idle cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr     <= 8'd0;
            cnt      <= 9'd0;
            acc      <= 8'd0;
            hi_bits  <= 7'd0;
            tmr      <= '0;
            rx_ready <= 1'b0;
            im_we    <= 1'b0;
            im_waddr <= 8'd0;
            im_wdata <= 15'd0;
            cpu_hold <= 1'b0;
            pc_clear <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            im_we    <= 1'b0;
            done     <= 1'b0;
            pc_clear <= 1'b0;
            unique case (state)
                IDLE, ERR: begin
                    if (start) begin
                        state    <= LEN;
                        cpu_hold <= 1'b1;
                        err      <= 1'b0;
                        addr     <= 8'd0;
                        acc      <= 8'd0;
                        tmr      <= TMAX;
                        rx_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LEN, HI, LO, CHK: begin
                    if (xfer) begin
                        tmr <= TMAX;
                        unique case (state)
                            LEN: begin
                                cnt   <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                                acc   <= acc ^ rx_data;
                                state <= HI;
                            end
                            HI: begin
                                if (rx_data[7]) begin
                                    state    <= ERR;
                                    err      <= 1'b1;
                                    rx_ready <= 1'b0;
                                    busy     <= 1'b0;
                                end else begin
                                    hi_bits <= rx_data[6:0];
                                    acc     <= acc ^ rx_data;
                                    state   <= LO;
                                end
                            end
                            LO: begin
                                im_we    <= 1'b1;
                                im_waddr <= addr;
                                im_wdata <= {hi_bits, rx_data};
                                acc      <= acc ^ rx_data;
                                addr     <= addr + 8'd1;
                                cnt      <= cnt - 9'd1;
                                // Hold off one cycle so the write cycle accepts no byte.
                                rx_ready <= 1'b0;
                                state    <= (cnt != 9'd1) ? HI : CHK;
                            end
                            default: begin
                                rx_ready <= 1'b0;
                                if (rx_data == acc) begin
                                    state    <= DONE;
                                    done     <= 1'b1;
                                    pc_clear <= 1'b1;
                                end else begin
                                    state <= ERR;
                                    err   <= 1'b1;
                                    busy  <= 1'b0;
                                end
                            end
                        endcase
                    end else if (tmr == '0) begin
                        state    <= ERR;
                        err      <= 1'b1;
                        rx_ready <= 1'b0;
                        busy     <= 1'b0;
                    end else begin
                        tmr      <= tmr - 1'b1;
                        rx_ready <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    cpu_hold <= 1'b0;
                    busy     <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    rx_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a scoreboard of expected memory writes is filled
// as LO bytes are driven and drained by a monitor watching im_we.
module tb_program_loader;

    localparam int TO = 31;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        im_we;
    logic [7:0]  im_waddr;
    logic [14:0] im_wdata;
    logic        cpu_hold;
    logic        pc_clear;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;
    int n_writes = 0;
    int n_done = 0;
    logic [22:0] sb[$];
    logic [14:0] img[$];

    program_loader #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .im_we    (im_we),
        .im_waddr (im_waddr),
        .im_wdata (im_wdata),
        .cpu_hold (cpu_hold),
        .pc_clear (pc_clear),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor: every im_we must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && im_we) begin
            n_writes++;
            if (sb.size() == 0) begin
                chk("unexpected_we", 32'(im_waddr), 32'hFFFF_FFFF);
            end else begin
                logic [22:0] e;
                e = sb.pop_front();
                chk("we_addr", 32'(im_waddr), 32'(e[22:15]));
                chk("we_data", 32'(im_wdata), 32'(e[14:0]));
            end
        end
        if (rst_n && (done || pc_clear)) begin
            if (done) n_done++;
            chk("done_with_pcclr", 32'(pc_clear), 32'(done));
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Drive one byte after `gap` idle cycles; returns #1 after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        for (int i = 0; i < gap; i++) @(negedge clk);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (rx_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        rx_valid = 1'b0;
        if (!ok) chk("rx_ready_wait", 32'(0), 32'(1));
    endtask

    // Stream img[] as a full load; len_byte 0 means 256 words.
    task automatic run_load(input logic [7:0] len_byte, input bit bad_chk,
                            input int maxgap, input int mid_start);
        logic [7:0] x;
        logic [7:0] hb;
        int n;
        n = (len_byte == 8'd0) ? 256 : int'(len_byte);
        x = len_byte;
        send_byte(len_byte, $urandom_range(maxgap, 0));
        for (int i = 0; i < n; i++) begin
            if (i == mid_start) begin
                @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            hb = {1'b0, img[i][14:8]};
            x = x ^ hb ^ img[i][7:0];
            send_byte(hb, $urandom_range(maxgap, 0));
            sb.push_back({8'(i), img[i]});
            send_byte(img[i][7:0], $urandom_range(maxgap, 0));
        end
        send_byte(bad_chk ? (x ^ 8'h01) : x, $urandom_range(maxgap, 0));
    endtask

    task automatic check_done(input string tag, input int done_before);
        chk({tag, "_done"}, 32'(done), 32'(1));
        chk({tag, "_hold_in_done"}, 32'(cpu_hold), 32'(1));
        @(posedge clk);
        #1;
        chk({tag, "_hold_after"}, 32'(cpu_hold), 32'(0));
        chk({tag, "_done_once"}, 32'(n_done - done_before), 32'(1));
        chk({tag, "_err"}, 32'(err), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'(0));
    endtask

    initial begin
        int w0;
        int d0;
        #23;
        chk("rst_outputs", {rx_ready, im_we, cpu_hold, pc_clear, busy, done, err},
            7'b0);
        chk("rst_waddr", 32'(im_waddr), 32'(0));
        chk("rst_wdata", 32'(im_wdata), 32'(0));
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Good two-word load
        img = {15'h020F, 15'h0300};
        w0 = n_writes; d0 = n_done;
        pulse_start();
        chk("start_busy", 32'(busy), 32'(1));
        chk("start_hold", 32'(cpu_hold), 32'(1));
        chk("start_ready", 32'(rx_ready), 32'(1));
        run_load(8'h02, 1'b0, 0, -1);
        chk("good_writes", 32'(n_writes - w0), 32'(2));
        check_done("good", d0);

        // Bad checksum
        w0 = n_writes; d0 = n_done;
        pulse_start();
        run_load(8'h02, 1'b1, 0, -1);
        chk("badchk_writes", 32'(n_writes - w0), 32'(2));
        chk("badchk_err", 32'(err), 32'(1));
        chk("badchk_hold", 32'(cpu_hold), 32'(1));
        chk("badchk_ready", 32'(rx_ready), 32'(0));
        repeat (5) @(posedge clk);
        #1;
        chk("badchk_no_done", 32'(n_done - d0), 32'(0));
        chk("badchk_err_sticky", 32'(err), 32'(1));

        // Illegal HI byte, then recovery
        w0 = n_writes;
        pulse_start();
        chk("start_clears_err", 32'(err), 32'(0));
        send_byte(8'h01, 0);
        send_byte(8'h80, 0);
        chk("illhi_err", 32'(err), 32'(1));
        chk("illhi_busy", 32'(busy), 32'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("illhi_no_we", 32'(n_writes - w0), 32'(0));
        img = {15'h020F, 15'h0300};
        d0 = n_done;
        pulse_start();
        run_load(8'h02, 1'b0, 0, -1);
        check_done("recover", d0);

        // Timeout boundary: TO idle cycles tolerated, TO+1 fails
        pulse_start();
        repeat (TO) @(posedge clk);
        #1;
        chk("to_edge_ok", 32'(err), 32'(0));
        @(posedge clk);
        #1;
        chk("to_err", 32'(err), 32'(1));
        chk("to_busy", 32'(busy), 32'(0));

        // Gapped load just under the timeout
        img.delete();
        for (int i = 0; i < 5; i++) img.push_back(15'($urandom));
        d0 = n_done;
        pulse_start();
        run_load(8'h05, 1'b0, TO - 3, -1);
        check_done("gapped", d0);

        // Full 256-word image, random gaps, stray start mid-load
        img.delete();
        for (int i = 0; i < 256; i++) img.push_back(15'($urandom));
        w0 = n_writes; d0 = n_done;
        pulse_start();
        run_load(8'h00, 1'b0, 3, 100);
        chk("full_writes", 32'(n_writes - w0), 32'(256));
        check_done("full", d0);

        // Reset in mid-load: outputs drop without a clock edge
        img = {15'h1234, 15'h0055, 15'h7F7F, 15'h0001};
        pulse_start();
        send_byte(8'h04, 0);
        send_byte(8'h12, 0);
        sb.push_back({8'd0, 15'h1234});
        send_byte(8'h34, 0);
        send_byte(8'h00, 0);
        w0 = n_writes;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {rx_ready, im_we, cpu_hold, pc_clear, busy, done, err},
            7'b0);
        chk("midrst_waddr", 32'(im_waddr), 32'(0));
        chk("midrst_wdata", 32'(im_wdata), 32'(0));
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        chk("midrst_no_we", 32'(n_writes - w0), 32'(0));
        chk("midrst_idle_ready", 32'(rx_ready), 32'(0));
        chk("midrst_idle_busy", 32'(busy), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
